// File: rtl/axis_arb_mux.sv
// N-input AXI4-Stream mux with packet-locked arbitration (external select or
// round-robin) and a single registered, back-pressured output stage.
module axis_arb_mux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ARB_MODE   = 0,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  input  logic [NUM_CH-1:0]            s_tlast,
  output logic [NUM_CH-1:0]            s_tready,
  input  logic [CH_W-1:0]              sel,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic                         busy,
  output logic [CH_W-1:0]              cur_ch
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] cur_ch_r;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] cand;
  logic            cand_ok;
  logic            accept;
  logic            beat;
  int unsigned     idx;

  assign accept = !m_tvalid || m_tready;
  assign beat   = (state == PKT) && s_tvalid[grant] && accept;
  assign busy   = (state == PKT);
  assign cur_ch = cur_ch_r;

  // Candidate selection; round-robin scans rr_ptr+1 .. rr_ptr+NUM_CH so the
  // channel that just finished is considered last.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    idx     = 0;
    if (ARB_MODE == 0) begin
      if (32'(sel) < NUM_CH) begin
        cand    = sel;
        cand_ok = s_tvalid[sel];
      end
    end else begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        idx = 32'(rr_ptr) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!cand_ok && s_tvalid[idx]) begin
          cand    = CH_W'(idx);
          cand_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_tready  = '0;
    case (state)
      IDLE: begin
        if (cand_ok) state_nxt = PKT;
      end
      PKT: begin
        s_tready[grant] = accept;
        if (beat && s_tlast[grant]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      grant    <= '0;
      cur_ch_r <= '0;
      rr_ptr   <= CH_W'(NUM_CH - 1);
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cand_ok) begin
        grant    <= cand;
        cur_ch_r <= cand;
      end
      if (beat && s_tlast[grant]) rr_ptr <= grant;
      if (beat) begin
        m_tdata  <= s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
        m_tlast  <= s_tlast[grant];
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_arb_mux.sv
// Scoreboard bench: select-mode and round-robin instances of axis_arb_mux
// driven by directed packets; a negedge monitor checks each output beat.
module tb_axis_arb_mux;
  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 8;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [NCH*DW-1:0] s_tdata_v [2];
  logic [NCH-1:0]    s_tvalid_v[2];
  logic [NCH-1:0]    s_tlast_v [2];
  logic [1:0]        sel_v     [2];
  logic              m_tready_v[2];
  logic [NCH-1:0]    s_tready_w[2];

  logic [NCH-1:0] s_tready0, s_tready1;
  logic [DW-1:0]  m_tdata0, m_tdata1;
  logic           m_tvalid0, m_tvalid1, m_tlast0, m_tlast1, busy0, busy1;
  logic [1:0]     cur_ch0, cur_ch1;

  always_comb begin
    s_tready_w[0] = s_tready0;
    s_tready_w[1] = s_tready1;
  end

  axis_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ARB_MODE(0)) u_dut0 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s_tdata_v[0]), .s_tvalid(s_tvalid_v[0]), .s_tlast(s_tlast_v[0]),
    .s_tready(s_tready0), .sel(sel_v[0]),
    .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tlast(m_tlast0),
    .m_tready(m_tready_v[0]), .busy(busy0), .cur_ch(cur_ch0));

  axis_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ARB_MODE(1)) u_dut1 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s_tdata_v[1]), .s_tvalid(s_tvalid_v[1]), .s_tlast(s_tlast_v[1]),
    .s_tready(s_tready1), .sel(sel_v[1]),
    .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tlast(m_tlast1),
    .m_tready(m_tready_v[1]), .busy(busy1), .cur_ch(cur_ch1));

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic rr_gap_en = 1'b0;
  int   last_pop1 = -1;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] ch, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.ch = ch; e.data = d; e.last = l;
    return e;
  endfunction

  always @(negedge ACLK) begin
    if (ARESETn && m_tvalid0 && m_tready_v[0]) begin
      if (q0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL d0 unexpected beat: got 0x%0h expected none", m_tdata0);
      end else begin
        e0 = q0.pop_front();
        chk("d0 tdata", 32'(m_tdata0), 32'(e0.data));
        chk("d0 tlast", 32'(m_tlast0), 32'(e0.last));
      end
    end
    if (ARESETn && m_tvalid1 && m_tready_v[1]) begin
      if (q1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL d1 unexpected beat: got 0x%0h expected none", m_tdata1);
      end else begin
        e1 = q1.pop_front();
        chk("d1 tdata", 32'(m_tdata1), 32'(e1.data));
        chk("d1 tlast", 32'(m_tlast1), 32'(e1.last));
        chk("d1 cur_ch", 32'(cur_ch1), 32'(e1.ch));
      end
      if (rr_gap_en && last_pop1 >= 0) chk("d1 beat gap", 32'(cyc - last_pop1), 32'd2);
      last_pop1 = cyc;
    end
  end

  // Drives one packet on (d, ch); aborts if reset is asserted mid-packet.
  task automatic send_pkt(input int d, input int ch, input int n, input logic [DW-1:0] first,
                          input logic [DW-1:0] step, input bit push);
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] v;
      int t;
      v = first + DW'(k) * step;
      s_tdata_v[d][ch*DW +: DW] = v;
      s_tlast_v[d][ch] = (k == n - 1);
      s_tvalid_v[d][ch] = 1'b1;
      t = 0;
      @(negedge ACLK);
      while (!s_tready_w[d][ch] && ARESETn && t < 200) begin
        @(negedge ACLK);
        t++;
      end
      if (!ARESETn) break;
      if (t >= 200) begin
        vectors++; miscompares++;
        $display("FAIL send d%0d ch%0d: got no TREADY expected TREADY within 200 cycles", d, ch);
        break;
      end
      if (push) begin
        if (d == 0) q0.push_back(mk(2'(ch), v, k == n - 1));
        else        q1.push_back(mk(2'(ch), v, k == n - 1));
      end
      @(posedge ACLK);
      #1;
    end
    s_tvalid_v[d][ch] = 1'b0;
    s_tlast_v[d][ch]  = 1'b0;
  endtask

  task automatic wait_out0(input logic [DW-1:0] d);
    int t;
    t = 0;
    @(negedge ACLK);
    while (!(m_tvalid0 && m_tdata0 == d) && t < 200) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= 200) begin
      vectors++; miscompares++;
      $display("FAIL wait d0 output: got timeout expected beat 0x%0h", d);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_tdata_v[d] = '0; s_tvalid_v[d] = '0; s_tlast_v[d] = '0;
      sel_v[d] = '0; m_tready_v[d] = 1'b1;
    end

    repeat (3) @(negedge ACLK);
    chk("rst d0 m_tvalid", 32'(m_tvalid0), 0);
    chk("rst d0 m_tlast", 32'(m_tlast0), 0);
    chk("rst d0 m_tdata", 32'(m_tdata0), 0);
    chk("rst d0 s_tready", 32'(s_tready0), 0);
    chk("rst d0 busy", 32'(busy0), 0);
    chk("rst d0 cur_ch", 32'(cur_ch0), 0);
    chk("rst d1 m_tvalid", 32'(m_tvalid1), 0);
    chk("rst d1 m_tdata", 32'(m_tdata1), 0);
    chk("rst d1 s_tready", 32'(s_tready1), 0);
    chk("rst d1 busy", 32'(busy1), 0);
    chk("rst d1 cur_ch", 32'(cur_ch1), 0);
    ARESETn = 1'b1;
    idle_cycles(1);

    // Select mode: 3-beat packet on ch2, latency and per-channel TREADY
    sel_v[0] = 2'd2;
    fork
      send_pkt(0, 2, 3, 8'h11, 8'h11, 1'b1);
      begin
        @(negedge ACLK);
        chk("t1 idle busy", 32'(busy0), 0);
        chk("t1 idle s_tready", 32'(s_tready0), 0);
        @(negedge ACLK);
        chk("t1 grant busy", 32'(busy0), 1);
        chk("t1 grant s_tready", 32'(s_tready0), 32'b0100);
        chk("t1 bubble m_tvalid", 32'(m_tvalid0), 0);
        @(negedge ACLK);
        chk("t1 first m_tvalid", 32'(m_tvalid0), 1);
        chk("t1 first m_tdata", 32'(m_tdata0), 32'h11);
        chk("t1 others s_tready", 32'(s_tready0 & 4'b1011), 0);
        @(negedge ACLK);
        chk("t1 second m_tdata", 32'(m_tdata0), 32'h22);
        @(negedge ACLK);
        chk("t1 third m_tdata", 32'(m_tdata0), 32'h33);
        chk("t1 third m_tlast", 32'(m_tlast0), 1);
        chk("t1 others s_tready end", 32'(s_tready0 & 4'b1011), 0);
      end
    join
    idle_cycles(2);

    // Packet lock: sel moves to ch0 after the first ch2 beat
    sel_v[0] = 2'd2;
    fork
      send_pkt(0, 2, 3, 8'h61, 8'h01, 1'b1);
      send_pkt(0, 0, 2, 8'h71, 8'h01, 1'b1);
      begin
        int t;
        t = 0;
        @(negedge ACLK);
        while (!s_tready0[2] && t < 200) begin @(negedge ACLK); t++; end
        @(posedge ACLK); #1;
        sel_v[0] = 2'd0;
        t = 0;
        @(negedge ACLK);
        while (!(s_tready0[2] && s_tlast_v[0][2]) && t < 200) begin @(negedge ACLK); t++; end
        chk("t2 lock wait", 32'(t < 200), 1);
        @(negedge ACLK);
        chk("t2 idle busy", 32'(busy0), 0);
        chk("t2 idle s_tready", 32'(s_tready0), 0);
        @(negedge ACLK);
        chk("t2 ch0 busy", 32'(busy0), 1);
        chk("t2 ch0 cur_ch", 32'(cur_ch0), 0);
        chk("t2 ch0 s_tready", 32'(s_tready0), 32'b0001);
      end
    join
    idle_cycles(2);

    // Backpressure: 5 stalled cycles mid-packet
    sel_v[0] = 2'd3;
    fork
      send_pkt(0, 3, 6, 8'h31, 8'h01, 1'b1);
      begin
        wait_out0(8'h32);
        @(posedge ACLK); #1;
        m_tready_v[0] = 1'b0;
        repeat (5) begin
          @(negedge ACLK);
          chk("t3 stall m_tdata", 32'(m_tdata0), 32'h33);
          chk("t3 stall m_tlast", 32'(m_tlast0), 0);
          chk("t3 stall m_tvalid", 32'(m_tvalid0), 1);
          chk("t3 stall s_tready", 32'(s_tready0), 0);
        end
        @(posedge ACLK); #1;
        m_tready_v[0] = 1'b1;
      end
    join
    idle_cycles(3);

    // Reset in the middle of a 4-beat packet
    sel_v[0] = 2'd1;
    fork
      send_pkt(0, 1, 4, 8'h41, 8'h01, 1'b1);
      begin
        wait_out0(8'h42);
        ARESETn = 1'b0;
        #1;
        q0.delete();
        chk("t4 rst m_tvalid", 32'(m_tvalid0), 0);
        chk("t4 rst busy", 32'(busy0), 0);
        chk("t4 rst s_tready", 32'(s_tready0), 0);
        chk("t4 rst m_tdata", 32'(m_tdata0), 0);
        sel_v[0] = 2'd0;
        repeat (3) @(negedge ACLK);
        q0.delete();
        ARESETn = 1'b1;
      end
    join
    idle_cycles(1);
    send_pkt(0, 0, 3, 8'h51, 8'h01, 1'b1);
    idle_cycles(3);

    // Round-robin: all channels valid, 1-beat packets, order 0,1,2,3,0
    q1.push_back(mk(2'd0, 8'hA0, 1'b1));
    q1.push_back(mk(2'd1, 8'hA1, 1'b1));
    q1.push_back(mk(2'd2, 8'hA2, 1'b1));
    q1.push_back(mk(2'd3, 8'hA3, 1'b1));
    q1.push_back(mk(2'd0, 8'hB0, 1'b1));
    last_pop1 = -1;
    rr_gap_en = 1'b1;
    fork
      begin
        send_pkt(1, 0, 1, 8'hA0, 8'h00, 1'b0);
        send_pkt(1, 0, 1, 8'hB0, 8'h00, 1'b0);
      end
      send_pkt(1, 1, 1, 8'hA1, 8'h00, 1'b0);
      send_pkt(1, 2, 1, 8'hA2, 8'h00, 1'b0);
      send_pkt(1, 3, 1, 8'hA3, 8'h00, 1'b0);
    join
    idle_cycles(3);
    rr_gap_en = 1'b0;

    // Round-robin fairness: ch3 alone, then ch1 and ch3 together
    q1.push_back(mk(2'd3, 8'hC0, 1'b0));
    q1.push_back(mk(2'd3, 8'hC1, 1'b1));
    q1.push_back(mk(2'd1, 8'hE0, 1'b1));
    q1.push_back(mk(2'd3, 8'hD0, 1'b1));
    send_pkt(1, 3, 2, 8'hC0, 8'h01, 1'b0);
    fork
      send_pkt(1, 1, 1, 8'hE0, 8'h00, 1'b0);
      send_pkt(1, 3, 1, 8'hD0, 8'h00, 1'b0);
    join

    for (int t = 0; t < 100 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge ACLK);
    chk("d0 queue drained", 32'(q0.size()), 0);
    chk("d1 queue drained", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
